// File: rtl/mem_access_cmd_ctrl.sv
// mem_access_cmd_ctrl
//   Host command sequencer sitting between the UART byte receiver/transmitter
//   and the single-port register-file RAM. It parses byte commands, drives
//   the RAM port, returns one response byte per command, aborts stalled
//   partial commands after an inter-byte timeout and range-checks addresses.
//
//   Commands : 'W' 0x57 addr data -> 'K' 0x4B
//              'R' 0x52 addr      -> read data byte
//              any error          -> 'E' 0x45
//   Optional : define MEM_ACCESS_BURST_EN to add 'B' 0x42 addr len, which
//              streams len bytes starting at addr (address wraps modulo DEPTH).
//              Without the macro 0x42 is an unknown opcode.
//
//   Ports
//     clk, rst            clock, synchronous active-high reset
//     rx_data, rx_valid   received byte and its one-cycle strobe
//     tx_data, tx_start   response byte and one-cycle transmit request
//     tx_ready            transmitter idle
//     mem_addr, mem_wdata RAM address / write data (hold between strobes)
//     mem_wr_en, mem_rd_en one-cycle RAM strobes; read data valid next cycle
//     mem_rdata           RAM read data
//     busy                high whenever the sequencer is not idle
//     rx_drop             byte arrived while not accepting bytes
//     timeout             partial command aborted
module mem_access_cmd_ctrl #(
  parameter  int DEPTH       = 256,
  parameter  int TIMEOUT_CYC = 100000,
  localparam int AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic [7:0]    tx_data,
  output logic          tx_start,
  input  logic          tx_ready,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  output logic          mem_wr_en,
  output logic          mem_rd_en,
  input  logic [7:0]    mem_rdata,
  output logic          busy,
  output logic          rx_drop,
  output logic          timeout
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [7:0] OP_WR  = 8'h57;
  localparam logic [7:0] OP_RD  = 8'h52;
  localparam logic [7:0] RSP_OK = 8'h4B;
  localparam logic [7:0] RSP_ER = 8'h45;

  typedef enum logic [3:0] {
    IDLE, GET_ADDR, GET_DATA, MEM_WR, MEM_RD, RD_CAP, SEND, SEND_HOLD
`ifdef MEM_ACCESS_BURST_EN
    , GET_LEN, BURST_RD, BURST_CAP, BURST_SEND
`endif
  } state_t;

  state_t        state, state_n;
  logic [7:0]    op_q, op_n;
  logic [AW-1:0] addr_q, addr_n;
  logic [AW-1:0] mem_addr_n;
  logic [7:0]    mem_wdata_n;
  logic [7:0]    tx_data_n;
  logic          hold_q, hold_n;
  logic [CW-1:0] cnt_q;
  logic          waiting, receiving, expired, is_op, addr_bad;

`ifdef MEM_ACCESS_BURST_EN
  localparam logic [7:0] OP_BU = 8'h42;
  logic [7:0] len_q, len_n;

  // Next burst address, wrapping at DEPTH even when DEPTH is not a power of two.
  function automatic logic [AW-1:0] addr_wrap(input logic [AW-1:0] a);
    return (int'(a) == DEPTH - 1) ? '0 : a + AW'(1);
  endfunction
`endif

`ifdef MEM_ACCESS_BURST_EN
  assign waiting = (state == GET_ADDR) || (state == GET_DATA) || (state == GET_LEN);
  assign is_op   = (rx_data == OP_WR) || (rx_data == OP_RD) || (rx_data == OP_BU);
`else
  assign waiting = (state == GET_ADDR) || (state == GET_DATA);
  assign is_op   = (rx_data == OP_WR) || (rx_data == OP_RD);
`endif

  assign receiving = (state == IDLE) || waiting;
  assign expired   = waiting && (cnt_q == CW'(TIMEOUT_CYC - 1));
  assign addr_bad  = {1'b0, rx_data} >= 9'(DEPTH);
  assign busy      = (state != IDLE);
  // A byte landing on the expiry cycle loses to the timeout and is dropped.
  assign rx_drop   = rx_valid && (!receiving || expired);
  assign timeout   = expired;

  always_comb begin
    state_n     = state;
    op_n        = op_q;
    addr_n      = addr_q;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    tx_data_n   = tx_data;
    hold_n      = 1'b0;
    mem_wr_en   = 1'b0;
    mem_rd_en   = 1'b0;
    tx_start    = 1'b0;
`ifdef MEM_ACCESS_BURST_EN
    len_n       = len_q;
`endif
    case (state)
      IDLE: begin
        if (rx_valid) begin
          if (is_op) begin
            op_n    = rx_data;
            state_n = GET_ADDR;
          end else begin
            tx_data_n = RSP_ER;
            state_n   = SEND;
          end
        end
      end
      GET_ADDR: begin
        if (expired) begin
          state_n = IDLE;
        end else if (rx_valid) begin
          if (addr_bad) begin
            tx_data_n = RSP_ER;
            state_n   = SEND;
          end else begin
            addr_n = rx_data[AW-1:0];
            if (op_q == OP_WR) begin
              state_n = GET_DATA;
`ifdef MEM_ACCESS_BURST_EN
            end else if (op_q == OP_BU) begin
              state_n = GET_LEN;
`endif
            end else begin
              mem_addr_n = rx_data[AW-1:0];
              state_n    = MEM_RD;
            end
          end
        end
      end
      GET_DATA: begin
        if (expired) begin
          state_n = IDLE;
        end else if (rx_valid) begin
          mem_addr_n  = addr_q;
          mem_wdata_n = rx_data;
          state_n     = MEM_WR;
        end
      end
      MEM_WR: begin
        mem_wr_en = 1'b1;
        tx_data_n = RSP_OK;
        state_n   = SEND;
      end
      MEM_RD: begin
        mem_rd_en = 1'b1;
        state_n   = RD_CAP;
      end
      RD_CAP: begin
        tx_data_n = mem_rdata;
        state_n   = SEND;
      end
      SEND: begin
        if (tx_ready) begin
          tx_start = 1'b1;
          hold_n   = 1'b1;
          state_n  = SEND_HOLD;
        end
      end
      SEND_HOLD: begin
        // First cycle is blind: the transmitter may not have dropped tx_ready yet.
        if (!hold_q && tx_ready) begin
`ifdef MEM_ACCESS_BURST_EN
          if (len_q != 8'd0) begin
            mem_addr_n = addr_wrap(mem_addr);
            state_n    = BURST_RD;
          end else begin
            state_n = IDLE;
          end
`else
          state_n = IDLE;
`endif
        end
      end
`ifdef MEM_ACCESS_BURST_EN
      GET_LEN: begin
        if (expired) begin
          state_n = IDLE;
        end else if (rx_valid) begin
          if (rx_data == 8'd0) begin
            tx_data_n = RSP_ER;
            state_n   = SEND;
          end else begin
            len_n      = rx_data;
            mem_addr_n = addr_q;
            state_n    = BURST_RD;
          end
        end
      end
      BURST_RD: begin
        mem_rd_en = 1'b1;
        state_n   = BURST_CAP;
      end
      BURST_CAP: begin
        tx_data_n = mem_rdata;
        state_n   = BURST_SEND;
      end
      BURST_SEND: begin
        if (tx_ready) begin
          tx_start = 1'b1;
          hold_n   = 1'b1;
          len_n    = len_q - 8'd1;
          state_n  = SEND_HOLD;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= '0;
      addr_q    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      tx_data   <= '0;
      hold_q    <= 1'b0;
      cnt_q     <= '0;
`ifdef MEM_ACCESS_BURST_EN
      len_q     <= '0;
`endif
    end else begin
      state     <= state_n;
      op_q      <= op_n;
      addr_q    <= addr_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      tx_data   <= tx_data_n;
      hold_q    <= hold_n;
      // Inter-byte timer: runs only while waiting for a command byte.
      if (!waiting || rx_valid || expired) cnt_q <= '0;
      else                                 cnt_q <= cnt_q + CW'(1);
`ifdef MEM_ACCESS_BURST_EN
      len_q     <= len_n;
`endif
    end
  end

endmodule

// File: tb/tb_mem_access_cmd_ctrl.sv
// Testbench for mem_access_cmd_ctrl (DEPTH=16, TIMEOUT_CYC=50).
// A behavioural RAM answers the DUT's memory port; expected responses, writes
// and read addresses are queued when commands are driven and compared against
// what the DUT actually produced.
module tb_mem_access_cmd_ctrl;
  localparam int DEPTH       = 16;
  localparam int TIMEOUT_CYC = 50;
  localparam int AW          = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [7:0]    tx_data;
  logic          tx_start;
  logic          tx_ready;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_wr_en;
  logic          mem_rd_en;
  logic [7:0]    mem_rdata;
  logic          busy;
  logic          rx_drop;
  logic          timeout;

  always #5 clk = ~clk;

  mem_access_cmd_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_ready(tx_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr_en(mem_wr_en),
    .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata), .busy(busy),
    .rx_drop(rx_drop), .timeout(timeout)
  );

  // Behavioural RAM: read data valid the cycle after mem_rd_en.
  logic       preload;
  logic [7:0] ram [DEPTH];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= 8'(i * 7 + 3);
    end else begin
      if (mem_wr_en) ram[mem_addr] <= mem_wdata;
      if (mem_rd_en) mem_rdata <= ram[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  int tx_cnt = 0, wr_cnt = 0, rd_cnt = 0, drop_cnt = 0, to_cnt = 0, both_cnt = 0;
  int tx_cyc = 0, wr_cyc = 0, rd_cyc = 0, to_cyc = 0;
  logic [7:0]  obs_tx[$];
  logic [15:0] obs_wr[$];
  logic [7:0]  obs_rd[$];
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_start)  begin tx_cnt++; tx_cyc = cyc; obs_tx.push_back(tx_data); end
      if (mem_wr_en) begin wr_cnt++; wr_cyc = cyc; obs_wr.push_back({8'(mem_addr), mem_wdata}); end
      if (mem_rd_en) begin rd_cnt++; rd_cyc = cyc; obs_rd.push_back(8'(mem_addr)); end
      if (mem_wr_en && mem_rd_en) both_cnt++;
      if (rx_drop)   drop_cnt++;
      if (timeout)   begin to_cnt++; to_cyc = cyc; end
    end
  end

  logic [7:0]  ref_mem [DEPTH];
  logic [7:0]  exp_tx[$];
  logic [15:0] exp_wr[$];
  logic [7:0]  exp_rd[$];
  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic drain(input string tag);
    logic [7:0]  o8;
    logic [15:0] o16;
    while (obs_tx.size() > 0) begin
      o8 = obs_tx.pop_front();
      if (exp_tx.size() == 0) check({tag, "_tx_extra"}, 32'(o8), 32'h100);
      else                    check({tag, "_tx"}, 32'(o8), 32'(exp_tx.pop_front()));
    end
    check({tag, "_tx_missing"}, 32'(exp_tx.size()), 0);
    while (obs_wr.size() > 0) begin
      o16 = obs_wr.pop_front();
      if (exp_wr.size() == 0) check({tag, "_wr_extra"}, 32'(o16), 32'h10000);
      else                    check({tag, "_wr"}, 32'(o16), 32'(exp_wr.pop_front()));
    end
    check({tag, "_wr_missing"}, 32'(exp_wr.size()), 0);
    while (obs_rd.size() > 0) begin
      o8 = obs_rd.pop_front();
      if (exp_rd.size() == 0) check({tag, "_rd_extra"}, 32'(o8), 32'h100);
      else                    check({tag, "_rd_addr"}, 32'(o8), 32'(exp_rd.pop_front()));
    end
    check({tag, "_rd_missing"}, 32'(exp_rd.size()), 0);
    exp_tx.delete(); exp_wr.delete(); exp_rd.delete();
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 400) begin @(posedge clk); #1; k++; end
    check({tag, "_idle"}, 32'(busy), 0);
    repeat (2) @(posedge clk);
    #1;
    drain(tag);
  endtask

  task automatic cmd_write(input logic [7:0] a, input logic [7:0] d);
    int n;
    if (int'(a) < DEPTH) begin
      exp_wr.push_back({a, d});
      ref_mem[int'(a)] = d;
      exp_tx.push_back(8'h4B);
      rx_byte(8'h57); rx_byte(a);
      n = cyc;
      rx_byte(d);
      wait_idle("wr");
      check("wr_lat", 32'(wr_cyc - n), 1);
      check("wr_tx_lat", 32'(tx_cyc - n), 2);
    end else begin
      exp_tx.push_back(8'h45);
      rx_byte(8'h57); rx_byte(a);
      wait_idle("wr_range");
    end
  endtask

  task automatic cmd_read(input logic [7:0] a);
    int n;
    if (int'(a) < DEPTH) begin
      exp_rd.push_back(a);
      exp_tx.push_back(ref_mem[int'(a)]);
      rx_byte(8'h52);
      n = cyc;
      rx_byte(a);
      wait_idle("rd");
      check("rd_lat", 32'(rd_cyc - n), 1);
      check("rd_tx_lat", 32'(tx_cyc - n), 3);
    end else begin
      exp_tx.push_back(8'h45);
      rx_byte(8'h52); rx_byte(a);
      wait_idle("rd_range");
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end

  initial begin
    int n, c0, c1;
    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; tx_ready = 1'b1; preload = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'(i * 7 + 3);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; preload = 1'b0;

    // reset state
    check("rst_busy", 32'(busy), 0);
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_tx_data", 32'(tx_data), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_wr_rd", 32'({mem_wr_en, mem_rd_en}), 0);
    check("rst_drop_to", 32'({rx_drop, timeout}), 0);

    // write then read back, plus boundary addresses
    cmd_write(8'h0A, 8'hA5);
    cmd_read(8'h0A);
    cmd_write(8'h0F, 8'h5C);
    cmd_read(8'h0F);
    cmd_read(8'h03);

    // errors: unknown opcode, address out of range
    c0 = wr_cnt; c1 = rd_cnt;
    exp_tx.push_back(8'h45);
    rx_byte(8'h33);
    wait_idle("bad_op");
    check("bad_op_strobes", 32'((wr_cnt - c0) + (rd_cnt - c1)), 0);
    cmd_read(8'h20);
    cmd_read(8'h10);
    cmd_write(8'h10, 8'h77);

    // timeout after the address byte of a write
    c0 = to_cnt; c1 = tx_cnt;
    rx_byte(8'h57);
    n = cyc;
    rx_byte(8'h05);
    repeat (55) @(posedge clk);
    #1;
    check("to_pulse", 32'(to_cnt - c0), 1);
    check("to_cycle", 32'(to_cyc - n), 50);
    check("to_busy", 32'(busy), 0);
    check("to_no_tx", 32'(tx_cnt - c1), 0);
    drain("to");
    cmd_read(8'h05);

    // byte arriving exactly on the expiry cycle
    c0 = to_cnt; c1 = drop_cnt;
    rx_byte(8'h57);
    n = cyc;
    rx_byte(8'h06);
    repeat (49) @(posedge clk);
    #1;
    check("to_col_cycle", 32'(cyc - n), 50);
    rx_byte(8'hC3);
    repeat (3) @(posedge clk);
    #1;
    check("to_col_pulse", 32'(to_cnt - c0), 1);
    check("to_col_drop", 32'(drop_cnt - c1), 1);
    check("to_col_busy", 32'(busy), 0);
    drain("to_col");
    cmd_read(8'h06);

    // backpressure and dropped byte
    tx_ready = 1'b0;
    c0 = tx_cnt; c1 = drop_cnt;
    exp_rd.push_back(8'h01);
    exp_tx.push_back(ref_mem[1]);
    rx_byte(8'h52); rx_byte(8'h01);
    repeat (8) @(posedge clk);
    #1;
    check("bp_wait_tx", 32'(tx_cnt - c0), 0);
    check("bp_busy", 32'(busy), 1);
    rx_byte(8'h52);
    check("bp_drop", 32'(drop_cnt - c1), 1);
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_tx_stable", 32'(tx_data), 32'(ref_mem[1]));
    end
    check("bp_hold_busy", 32'(busy), 1);
    tx_ready = 1'b1;
    wait_idle("bp");
    check("bp_one_start", 32'(tx_cnt - c0), 1);

    // reset in the middle of a write
    c0 = wr_cnt;
    rx_byte(8'h57); rx_byte(8'h07);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_tx_data", 32'(tx_data), 0);
    check("mid_rst_mem_addr", 32'(mem_addr), 0);
    check("mid_rst_mem_wdata", 32'(mem_wdata), 0);
    check("mid_rst_strobes", 32'({tx_start, mem_wr_en, mem_rd_en, rx_drop, timeout}), 0);
    exp_tx.push_back(8'h45);
    rx_byte(8'hAA);
    wait_idle("mid_rst");
    check("mid_rst_no_wr", 32'(wr_cnt - c0), 0);
    cmd_read(8'h07);

`ifdef MEM_ACCESS_BURST_EN
    cmd_write(8'h0E, 8'h11);
    cmd_write(8'h0F, 8'h22);
    cmd_write(8'h00, 8'h33);
    exp_rd.push_back(8'h0E); exp_rd.push_back(8'h0F); exp_rd.push_back(8'h00);
    exp_tx.push_back(8'h11); exp_tx.push_back(8'h22); exp_tx.push_back(8'h33);
    rx_byte(8'h42); rx_byte(8'h0E); rx_byte(8'h03);
    wait_idle("burst");
    exp_tx.push_back(8'h45);
    rx_byte(8'h42); rx_byte(8'h00); rx_byte(8'h00);
    wait_idle("burst_len0");
    exp_tx.push_back(8'h45);
    rx_byte(8'h42); rx_byte(8'h10);
    wait_idle("burst_range");
`else
    exp_tx.push_back(8'h45);
    rx_byte(8'h42);
    wait_idle("no_burst");
`endif

    check("wr_rd_exclusive", 32'(both_cnt), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
